// File: rtl/obi_mem_bist_master.sv
// ============================================================================
// Module   : obi_mem_bist_master
// Brief    : OBI initiator that fills a word range with an address-derived
//            pattern and optionally reads it back and counts mismatches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package eros_obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module obi_mem_bist_master
    import eros_obi_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [31:0]          base_addr_i,
    input  logic [LEN_WIDTH-1:0] num_words_i,
    input  logic [31:0]          seed_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [LEN_WIDTH-1:0] err_count_o,
    output logic [31:0]          first_err_addr_o,
    output obi_req_t             obi_req_o,
    input  obi_resp_t            obi_resp_i
);

    localparam int                   c_OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_OUT_W-1:0]   c_MAX_OUT = c_OUT_W'(MAX_OUTSTANDING);
    localparam logic [LEN_WIDTH-1:0] c_CNT_MAX = '1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_ISSUE = 3'd1;
    localparam logic [2:0] S_WR_DRAIN = 3'd2;
    localparam logic [2:0] S_RD_ISSUE = 3'd3;
    localparam logic [2:0] S_RD_DRAIN = 3'd4;
    localparam logic [2:0] S_FINISH   = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_state_n;
    logic                 r_chk;
    logic [31:0]          r_base;
    logic [LEN_WIDTH-1:0] r_num;
    logic [31:0]          r_seed;
    logic [LEN_WIDTH-1:0] r_issue_idx;
    logic [LEN_WIDTH-1:0] r_rsp_idx;
    logic [c_OUT_W-1:0]   r_outstanding;
    logic                 r_req;
    logic                 r_we;
    logic [3:0]           r_be;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic                 r_error;
    logic [LEN_WIDTH-1:0] r_err_count;
    logic [31:0]          r_first_err;

    logic                 w_start;
    logic                 w_hs;
    logic                 w_rsp;
    logic [c_OUT_W-1:0]   w_out_n;
    logic [LEN_WIDTH-1:0] w_idx_n;
    logic                 w_issue_state;
    logic                 w_rd_phase;
    logic                 w_req_n;
    logic [31:0]          w_addr_n;
    logic [31:0]          w_rsp_addr;
    logic                 w_mismatch;

    assign w_start       = (r_state == S_IDLE) && start_i;
    assign w_hs          = r_req && obi_resp_i.gnt;
    // Responses with nothing in flight (e.g. stragglers after a reset) are dropped.
    assign w_rsp         = obi_resp_i.rvalid && (r_outstanding != '0);
    assign w_idx_n       = r_issue_idx + LEN_WIDTH'(w_hs);
    assign w_issue_state = (r_state == S_WR_ISSUE) || (r_state == S_RD_ISSUE);
    assign w_rd_phase    = (r_state == S_RD_ISSUE) || (r_state == S_RD_DRAIN);
    assign w_addr_n      = r_base + 32'({w_idx_n, 2'b00});
    assign w_rsp_addr    = r_base + 32'({r_rsp_idx, 2'b00});
    assign w_mismatch    = w_rsp && w_rd_phase &&
                           (obi_resp_i.rdata != (w_rsp_addr ^ r_seed));

    always_comb begin
        w_out_n = r_outstanding;
        case ({w_hs, w_rsp})
            2'b10:   w_out_n = r_outstanding + 1'b1;
            2'b01:   w_out_n = r_outstanding - 1'b1;
            default: w_out_n = r_outstanding;
        endcase
    end

    // Next request looks ahead at this cycle's grant and response so that a
    // zero-wait slave sees one transaction per cycle.
    assign w_req_n = w_issue_state && (w_idx_n < r_num) && (w_out_n < c_MAX_OUT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (num_words_i == '0) begin
                        w_state_n = S_FINISH;
                    end else if (mode_i == 2'b01) begin
                        w_state_n = S_RD_ISSUE;
                    end else begin
                        w_state_n = S_WR_ISSUE;
                    end
                end
            end
            S_WR_ISSUE: if (r_issue_idx == r_num) w_state_n = S_WR_DRAIN;
            S_WR_DRAIN: if (r_outstanding == '0) w_state_n = r_chk ? S_RD_ISSUE : S_FINISH;
            S_RD_ISSUE: if (r_issue_idx == r_num) w_state_n = S_RD_DRAIN;
            S_RD_DRAIN: if (r_outstanding == '0) w_state_n = S_FINISH;
            S_FINISH:   w_state_n = S_IDLE;
            default:    w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            S_IDLE:   busy_o = 1'b0;
            S_FINISH: done_o = 1'b1;
            default:  busy_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_chk         <= 1'b0;
            r_base        <= '0;
            r_num         <= '0;
            r_seed        <= '0;
            r_issue_idx   <= '0;
            r_rsp_idx     <= '0;
            r_outstanding <= '0;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_be          <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_error       <= 1'b0;
            r_err_count   <= '0;
            r_first_err   <= '0;
        end else begin
            r_outstanding <= w_out_n;
            r_issue_idx   <= w_idx_n;

            if (w_rsp && w_rd_phase) begin
                r_rsp_idx <= r_rsp_idx + 1'b1;
            end
            if (w_mismatch) begin
                r_error <= 1'b1;
                if (r_err_count != c_CNT_MAX) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                if (r_err_count == '0) begin
                    r_first_err <= w_rsp_addr;
                end
            end

            // A request waiting for its grant must not change.
            if (!(r_req && !obi_resp_i.gnt)) begin
                r_req   <= w_req_n;
                r_we    <= w_req_n && (r_state == S_WR_ISSUE);
                r_be    <= {4{w_req_n}};
                r_addr  <= w_req_n ? w_addr_n : 32'h0;
                r_wdata <= (w_req_n && (r_state == S_WR_ISSUE)) ? (w_addr_n ^ r_seed) : 32'h0;
            end

            if ((r_state == S_WR_DRAIN) && (w_state_n == S_RD_ISSUE)) begin
                r_issue_idx <= '0;
                r_rsp_idx   <= '0;
            end

            if (w_start) begin
                r_chk       <= mode_i[1];
                r_base      <= {base_addr_i[31:2], 2'b00};
                r_num       <= num_words_i;
                r_seed      <= seed_i;
                r_issue_idx <= '0;
                r_rsp_idx   <= '0;
                r_error     <= 1'b0;
                r_err_count <= '0;
                r_first_err <= '0;
            end
        end
    end

    assign error_o          = r_error;
    assign err_count_o      = r_err_count;
    assign first_err_addr_o = r_first_err;

    assign obi_req_o.req   = r_req;
    assign obi_req_o.we    = r_we;
    assign obi_req_o.be    = r_be;
    assign obi_req_o.addr  = r_addr;
    assign obi_req_o.wdata = r_wdata;

endmodule

`default_nettype wire
